// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity bit, one stop bit. One clock cycle per bit period.
// TX_OUT and busy are both registered, so the line changes only on clock edges.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity of the latched word; odd_sel=1 selects odd parity.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic odd_sel);
        return (^d) ^ odd_sel;
    endfunction

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic                  par_en_r, par_en_s;
    logic                  par_typ_r, par_typ_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [IDX_W-1:0]      idx_inc_s;
    logic                  tx_s;
    logic                  busy_s;

    assign idx_inc_s = idx_r + IDX_W'(1'b1);

    // Next-state and next-output decode; outputs are computed one edge ahead
    // so the registered line carries the bit for the state being entered.
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        par_en_s  = par_en_r;
        par_typ_s = par_typ_r;
        idx_s     = idx_r;
        tx_s      = 1'b1;
        busy_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Data_Valid) begin
                    data_s    = P_DATA;
                    par_en_s  = PAR_EN;
                    par_typ_s = PAR_TYP;
                    idx_s     = {IDX_W{1'b0}};
                    tx_s      = 1'b0;
                    busy_s    = 1'b1;
                    state_s   = ST_START;
                end else begin
                    tx_s   = 1'b1;
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                idx_s   = {IDX_W{1'b0}};
                tx_s    = data_r[0];
                busy_s  = 1'b1;
                state_s = ST_DATA;
            end
            ST_DATA: begin
                busy_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    // Index resets only as the state leaves DATA.
                    idx_s = {IDX_W{1'b0}};
                    if (par_en_r) begin
                        tx_s    = calc_parity(data_r, par_typ_r);
                        state_s = ST_PARITY;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end
                end else begin
                    idx_s = idx_inc_s;
                    tx_s  = data_r[idx_inc_s];
                end
            end
            ST_PARITY: begin
                tx_s    = 1'b1;
                busy_s  = 1'b1;
                state_s = ST_STOP;
            end
            ST_STOP: begin
                // Dropping busy here leaves one idle-high cycle before the
                // next request can be sampled.
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                idx_s   = {IDX_W{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched frame contents and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            data_r    <= {DATA_WIDTH{1'b0}};
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            data_r    <= data_s;
            par_en_r  <= par_en_s;
            par_typ_r <= par_typ_s;
            idx_r     <= idx_s;
            TX_OUT    <= tx_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a queue-based frame model
// predicts the line and busy every cycle; directed frames pin literal values.
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic cap_tx [0:31];
    logic cap_busy [0:31];
    int   cap_n = 0;

    // Behavioural model: a frame is a list of line bits, one per cycle.
    bit   mq [$];
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Reference: emit queued frame bits; accept a request only after a
    // cycle in which the line was not busy.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mq.delete();
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
        end else if (mq.size() > 0) begin
            exp_tx   <= mq.pop_front();
            exp_busy <= 1'b1;
        end else if (!exp_busy && Data_Valid) begin
            for (int i = 0; i < 8; i++) mq.push_back(P_DATA[i]);
            if (PAR_EN) mq.push_back((^P_DATA) ^ PAR_TYP);
            mq.push_back(1'b1);
            exp_tx   <= 1'b0;
            exp_busy <= 1'b1;
        end else begin
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle, compare against the model at the falling edge, capture.
    task automatic step();
        @(negedge CLK);
        check("model_tx", {31'd0, TX_OUT}, {31'd0, exp_tx});
        check("model_busy", {31'd0, busy}, {31'd0, exp_busy});
        if (cap_n < 32) begin
            cap_tx[cap_n]   = TX_OUT;
            cap_busy[cap_n] = busy;
            cap_n++;
        end
    endtask

    // One-cycle request; capture index 0 is the start bit.
    task automatic issue(input logic [7:0] d, input logic pe, input logic pt);
        cap_n      = 0;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
    endtask

    function automatic logic [7:0] cap_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap_tx[base + i];
        return b;
    endfunction

    function automatic int busy_count(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(cap_busy[i]);
        return c;
    endfunction

    initial begin
        logic [9:0] seq;

        // 1. Reset with toggling inputs, then a quiet line.
        repeat (5) begin
            P_DATA = 8'($urandom); Data_Valid = 1'($urandom);
            PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            step();
        end
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        RST = 1'b1; Data_Valid = 1'b0;
        cap_n = 0;
        repeat (20) step();
        check("idle_busy_cnt", busy_count(20), 32'd0);

        // 2. A5, no parity.
        issue(8'hA5, 1'b0, 1'b0);
        repeat (13) step();
        for (int i = 0; i < 10; i++) seq[i] = cap_tx[i];
        check("a5_seq", {22'd0, seq}, {22'd0, 10'b1101001010});
        check("a5_busy_cycles", busy_count(14), 32'd10);

        // 3. A5 with even then odd parity.
        issue(8'hA5, 1'b1, 1'b0);
        repeat (13) step();
        check("a5_even_par", {31'd0, cap_tx[9]}, 32'd0);
        check("a5_even_stop", {31'd0, cap_tx[10]}, 32'd1);
        check("a5_par_busy", busy_count(14), 32'd11);
        issue(8'hA5, 1'b1, 1'b1);
        repeat (13) step();
        check("a5_odd_par", {31'd0, cap_tx[9]}, 32'd1);

        // 4. 01 odd parity; inputs change mid-frame.
        issue(8'h01, 1'b1, 1'b1);
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (13) step();
        check("x01_data", {24'd0, cap_byte(1)}, {24'd0, 8'h01});
        check("x01_par", {31'd0, cap_tx[9]}, 32'd0);
        check("x01_busy", busy_count(14), 32'd11);

        // 5. Data_Valid held high: 3C then C3.
        cap_n = 0; PAR_EN = 1'b0; P_DATA = 8'h3C; Data_Valid = 1'b1;
        step();
        P_DATA = 8'hC3;
        repeat (24) step();
        Data_Valid = 1'b0;
        check("b2b_data1", {24'd0, cap_byte(1)}, {24'd0, 8'h3C});
        check("b2b_stop_busy", {31'd0, cap_busy[9]}, 32'd1);
        check("b2b_gap_tx", {31'd0, cap_tx[10]}, 32'd1);
        check("b2b_gap_busy", {31'd0, cap_busy[10]}, 32'd0);
        check("b2b_start2", {31'd0, cap_tx[11]}, 32'd0);
        check("b2b_data2", {24'd0, cap_byte(12)}, {24'd0, 8'hC3});
        repeat (14) step();

        // 6. Asynchronous reset during data bit 4, then a clean frame.
        issue(8'hA5, 1'b0, 1'b0);
        repeat (5) step();
        #2 RST = 1'b0;
        #1;
        check("midrst_tx", {31'd0, TX_OUT}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();
        RST = 1'b1;
        repeat (2) step();
        issue(8'h3C, 1'b1, 1'b0);
        repeat (13) step();
        check("post_rst_data", {24'd0, cap_byte(1)}, {24'd0, 8'h3C});
        check("post_rst_par", {31'd0, cap_tx[9]}, 32'd0);
        check("post_rst_busy", busy_count(14), 32'd11);

        // Random traffic, model-checked every cycle.
        for (int n = 0; n < 600; n++) begin
            Data_Valid = ($urandom_range(0, 2) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            step();
        end
        Data_Valid = 1'b0;
        repeat (14) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
